// File: rtl/scan_frame_loader.sv
// Streams host samples into the X then Y galvo tables, then arms the scan generator with a
// frame-ready pulse and waits for it to report completion.
module scan_frame_loader #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DATA_W       = 16,
    parameter logic [15:0] SCAN3D_STATE = 16'd3
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [15:0]       system_state,
    input  logic              load_start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] xdata_points_number,
    input  logic [ADDR_W-1:0] ydata_points_number,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              wr_x_en,
    output logic [ADDR_W-1:0] wr_x_addr,
    output logic [DATA_W-1:0] wr_x_data,
    output logic              wr_y_en,
    output logic [ADDR_W-1:0] wr_y_addr,
    output logic [DATA_W-1:0] wr_y_data,
    output logic              frame_rdy,
    input  logic              proc_finished,
    output logic              busy,
    output logic              load_err,
    output logic [15:0]       frames_done
);

    typedef enum logic [2:0] {StIdle, StLoadX, StLoadY, StArm, StRun, StErr} state_e;

    state_e            r_state, w_state_next;
    logic [ADDR_W-1:0] r_nx, w_nx_next;
    logic [ADDR_W-1:0] r_ny, w_ny_next;
    logic [ADDR_W-1:0] r_cnt, w_cnt_next;
    logic              r_wr_x_en, w_wr_x_en_next;
    logic [ADDR_W-1:0] r_wr_x_addr, w_wr_x_addr_next;
    logic [DATA_W-1:0] r_wr_x_data, w_wr_x_data_next;
    logic              r_wr_y_en, w_wr_y_en_next;
    logic [ADDR_W-1:0] r_wr_y_addr, w_wr_y_addr_next;
    logic [DATA_W-1:0] r_wr_y_data, w_wr_y_data_next;
    logic              r_frame_rdy, w_frame_rdy_next;
    logic              r_load_err, w_load_err_next;
    logic [15:0]       r_frames_done, w_frames_done_next;

    logic              w_hs;
    logic              w_cnt_last_x;
    logic              w_cnt_last_y;
    logic [15:0]       w_frames_inc;

    assign s_ready      = (r_state == StLoadX) || (r_state == StLoadY);
    assign w_hs         = s_valid && s_ready;
    assign w_cnt_last_x = (r_cnt == r_nx - ADDR_W'(1));
    assign w_cnt_last_y = (r_cnt == r_ny - ADDR_W'(1));
    assign w_frames_inc = (r_frames_done == 16'hFFFF) ? r_frames_done : r_frames_done + 16'd1;

    always_comb begin
        w_state_next       = r_state;
        w_nx_next          = r_nx;
        w_ny_next          = r_ny;
        w_cnt_next         = r_cnt;
        w_wr_x_en_next     = 1'b0;
        w_wr_x_addr_next   = r_wr_x_addr;
        w_wr_x_data_next   = r_wr_x_data;
        w_wr_y_en_next     = 1'b0;
        w_wr_y_addr_next   = r_wr_y_addr;
        w_wr_y_data_next   = r_wr_y_data;
        w_frame_rdy_next   = 1'b0;
        w_load_err_next    = r_load_err;
        w_frames_done_next = r_frames_done;

        if (abort) begin
            // A completion arriving alongside abort still counts as a finished frame.
            w_state_next    = StIdle;
            w_load_err_next = 1'b0;
            if ((r_state == StRun) && proc_finished) begin
                w_frames_done_next = w_frames_inc;
            end
        end else begin
            unique case (r_state)
                StIdle, StErr: begin
                    if (load_start) begin
                        w_nx_next       = xdata_points_number;
                        w_ny_next       = ydata_points_number;
                        w_cnt_next      = '0;
                        w_load_err_next = 1'b0;
                        if ((xdata_points_number == '0) || (ydata_points_number == '0)) begin
                            w_state_next    = StErr;
                            w_load_err_next = 1'b1;
                        end else begin
                            w_state_next = StLoadX;
                        end
                    end
                end
                StLoadX: begin
                    if (w_hs) begin
                        if (s_last) begin
                            w_state_next    = StErr;
                            w_load_err_next = 1'b1;
                        end else begin
                            w_wr_x_en_next   = 1'b1;
                            w_wr_x_addr_next = r_cnt;
                            w_wr_x_data_next = s_data;
                            if (w_cnt_last_x) begin
                                w_cnt_next   = '0;
                                w_state_next = StLoadY;
                            end else begin
                                w_cnt_next = r_cnt + ADDR_W'(1);
                            end
                        end
                    end
                end
                StLoadY: begin
                    if (w_hs) begin
                        if (w_cnt_last_y) begin
                            // The final Y sample lands even when s_last is missing.
                            w_wr_y_en_next   = 1'b1;
                            w_wr_y_addr_next = r_cnt;
                            w_wr_y_data_next = s_data;
                            if (s_last) begin
                                w_state_next = StArm;
                            end else begin
                                w_state_next    = StErr;
                                w_load_err_next = 1'b1;
                            end
                        end else if (s_last) begin
                            w_state_next    = StErr;
                            w_load_err_next = 1'b1;
                        end else begin
                            w_wr_y_en_next   = 1'b1;
                            w_wr_y_addr_next = r_cnt;
                            w_wr_y_data_next = s_data;
                            w_cnt_next       = r_cnt + ADDR_W'(1);
                        end
                    end
                end
                StArm: begin
                    if (system_state == SCAN3D_STATE) begin
                        w_frame_rdy_next = 1'b1;
                        w_state_next     = StRun;
                    end
                end
                StRun: begin
                    if (proc_finished) begin
                        w_frames_done_next = w_frames_inc;
                        w_state_next       = StIdle;
                    end
                end
                default: begin
                    w_state_next = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state       <= StIdle;
            r_nx          <= '0;
            r_ny          <= '0;
            r_cnt         <= '0;
            r_wr_x_en     <= 1'b0;
            r_wr_x_addr   <= '0;
            r_wr_x_data   <= '0;
            r_wr_y_en     <= 1'b0;
            r_wr_y_addr   <= '0;
            r_wr_y_data   <= '0;
            r_frame_rdy   <= 1'b0;
            r_load_err    <= 1'b0;
            r_frames_done <= '0;
        end else begin
            r_state       <= w_state_next;
            r_nx          <= w_nx_next;
            r_ny          <= w_ny_next;
            r_cnt         <= w_cnt_next;
            r_wr_x_en     <= w_wr_x_en_next;
            r_wr_x_addr   <= w_wr_x_addr_next;
            r_wr_x_data   <= w_wr_x_data_next;
            r_wr_y_en     <= w_wr_y_en_next;
            r_wr_y_addr   <= w_wr_y_addr_next;
            r_wr_y_data   <= w_wr_y_data_next;
            r_frame_rdy   <= w_frame_rdy_next;
            r_load_err    <= w_load_err_next;
            r_frames_done <= w_frames_done_next;
        end
    end

    assign wr_x_en     = r_wr_x_en;
    assign wr_x_addr   = r_wr_x_addr;
    assign wr_x_data   = r_wr_x_data;
    assign wr_y_en     = r_wr_y_en;
    assign wr_y_addr   = r_wr_y_addr;
    assign wr_y_data   = r_wr_y_data;
    assign frame_rdy   = r_frame_rdy;
    assign load_err    = r_load_err;
    assign frames_done = r_frames_done;
    assign busy        = (r_state != StIdle) && (r_state != StErr);

endmodule

// File: tb/tb_scan_frame_loader.sv
// Bench for scan_frame_loader: directed table loads plus randomized traffic, all checked every
// cycle against a sample-index model of the frame loading rules.
module tb_scan_frame_loader;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic [15:0] system_state = 16'd0;
    logic        load_start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] xdata_points_number = 16'd0;
    logic [15:0] ydata_points_number = 16'd0;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = 16'd0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic        wr_x_en;
    logic [15:0] wr_x_addr;
    logic [15:0] wr_x_data;
    logic        wr_y_en;
    logic [15:0] wr_y_addr;
    logic [15:0] wr_y_data;
    logic        frame_rdy;
    logic        proc_finished = 1'b0;
    logic        busy;
    logic        load_err;
    logic [15:0] frames_done;

    scan_frame_loader dut (
        .sys_clk             (sys_clk),
        .sys_rst             (sys_rst),
        .system_state        (system_state),
        .load_start          (load_start),
        .abort               (abort),
        .xdata_points_number (xdata_points_number),
        .ydata_points_number (ydata_points_number),
        .s_valid             (s_valid),
        .s_data              (s_data),
        .s_last              (s_last),
        .s_ready             (s_ready),
        .wr_x_en             (wr_x_en),
        .wr_x_addr           (wr_x_addr),
        .wr_x_data           (wr_x_data),
        .wr_y_en             (wr_y_en),
        .wr_y_addr           (wr_y_addr),
        .wr_y_data           (wr_y_data),
        .frame_rdy           (frame_rdy),
        .proc_finished       (proc_finished),
        .busy                (busy),
        .load_err            (load_err),
        .frames_done         (frames_done)
    );

    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a load is a run of accepted samples indexed k; k < nx goes to X, the rest to Y.
    localparam int MIdle = 0, MLoad = 1, MArm = 2, MRun = 3, MErr = 4;
    int m_mode, m_k, m_nx, m_ny, m_frames;
    bit m_err;
    bit e_wx_en, e_wy_en, e_frdy;
    int e_wx_addr, e_wy_addr, e_wx_data, e_wy_data;

    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            m_mode = MIdle; m_k = 0; m_nx = 0; m_ny = 0; m_frames = 0; m_err = 0;
            e_wx_en = 0; e_wy_en = 0; e_frdy = 0;
            e_wx_addr = 0; e_wy_addr = 0; e_wx_data = 0; e_wy_data = 0;
        end else begin
            e_wx_en = 0; e_wy_en = 0; e_frdy = 0;
            if (abort) begin
                if (m_mode == MRun && proc_finished && m_frames < 65535) m_frames++;
                m_mode = MIdle;
                m_err  = 0;
            end else if (m_mode == MIdle || m_mode == MErr) begin
                if (load_start) begin
                    m_nx = int'(xdata_points_number);
                    m_ny = int'(ydata_points_number);
                    m_k = 0;
                    m_err = 0;
                    if (m_nx == 0 || m_ny == 0) begin m_mode = MErr; m_err = 1; end
                    else m_mode = MLoad;
                end
            end else if (m_mode == MLoad) begin
                if (s_valid) begin
                    if (m_k < m_nx) begin
                        if (s_last) begin m_mode = MErr; m_err = 1; end
                        else begin
                            e_wx_en = 1; e_wx_addr = m_k; e_wx_data = int'(s_data); m_k++;
                        end
                    end else if (m_k - m_nx == m_ny - 1) begin
                        e_wy_en = 1; e_wy_addr = m_k - m_nx; e_wy_data = int'(s_data);
                        m_mode = s_last ? MArm : MErr;
                        m_err  = !s_last;
                    end else if (s_last) begin
                        m_mode = MErr; m_err = 1;
                    end else begin
                        e_wy_en = 1; e_wy_addr = m_k - m_nx; e_wy_data = int'(s_data); m_k++;
                    end
                end
            end else if (m_mode == MArm) begin
                if (system_state == 16'd3) begin e_frdy = 1; m_mode = MRun; end
            end else if (m_mode == MRun) begin
                if (proc_finished) begin
                    if (m_frames < 65535) m_frames++;
                    m_mode = MIdle;
                end
            end
        end
    end

    always @(negedge sys_clk) begin
        check("s_ready", {31'd0, s_ready}, {31'd0, m_mode == MLoad});
        check("busy", {31'd0, busy},
              {31'd0, (m_mode == MLoad) || (m_mode == MArm) || (m_mode == MRun)});
        check("load_err", {31'd0, load_err}, {31'd0, m_err});
        check("frames_done", {16'd0, frames_done}, m_frames);
        check("frame_rdy", {31'd0, frame_rdy}, {31'd0, e_frdy});
        check("wr_x_en", {31'd0, wr_x_en}, {31'd0, e_wx_en});
        check("wr_y_en", {31'd0, wr_y_en}, {31'd0, e_wy_en});
        if (e_wx_en) begin
            check("wr_x_addr", {16'd0, wr_x_addr}, e_wx_addr);
            check("wr_x_data", {16'd0, wr_x_data}, e_wx_data);
        end
        if (e_wy_en) begin
            check("wr_y_addr", {16'd0, wr_y_addr}, e_wy_addr);
            check("wr_y_data", {16'd0, wr_y_data}, e_wy_data);
        end
    end

    // Observed traffic, used by the literal expectations in the directed tests.
    int cyc = 0, wx_cnt = 0, wy_cnt = 0, frdy_cnt = 0, frdy_cyc = 0, last_hs_cyc = 0;
    logic [15:0] mem_x [16];
    logic [15:0] mem_y [16];
    int q_xa[$];
    int q_ya[$];

    always @(posedge sys_clk) cyc++;

    always @(negedge sys_clk) begin
        if (wr_x_en === 1'b1) begin
            wx_cnt++; mem_x[wr_x_addr[3:0]] = wr_x_data; q_xa.push_back(int'(wr_x_addr));
        end
        if (wr_y_en === 1'b1) begin
            wy_cnt++; mem_y[wr_y_addr[3:0]] = wr_y_data; q_ya.push_back(int'(wr_y_addr));
        end
        if (s_valid && s_ready === 1'b1) last_hs_cyc = cyc;
        if (frame_rdy === 1'b1) begin frdy_cnt++; frdy_cyc = cyc; end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic start_load(input int nx, input int ny);
        xdata_points_number = 16'(nx);
        ydata_points_number = 16'(ny);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send(input int d, input bit last, input int gap);
        s_valid = 1'b0;
        repeat (gap) tick();
        s_valid = 1'b1;
        s_data  = 16'(d);
        s_last  = last;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_frdy(input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (frame_rdy === 1'b1) seen = 1;
        end
        check("frame_rdy_wait", {31'd0, seen}, 32'd1);
    endtask

    task automatic pulse_pf();
        proc_finished = 1'b1;
        tick();
        proc_finished = 1'b0;
    endtask

    int wx0, wy0, f0;

    initial begin
        #1 sys_rst = 1'b1;
        #10;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_frames", {16'd0, frames_done}, 32'd0);
        check("rst_wr_x_en", {31'd0, wr_x_en}, 32'd0);
        #12 sys_rst = 1'b0;
        tick();

        // Nominal 4+3 load with the generator already in scan mode.
        system_state = 16'd3;
        wx0 = wx_cnt; wy0 = wy_cnt; f0 = frdy_cnt;
        start_load(4, 3);
        for (int i = 0; i < 7; i++) send(16'h10 + i, i == 6, 0);
        repeat (3) tick();
        check("n1_x_writes", wx_cnt - wx0, 32'd4);
        check("n1_y_writes", wy_cnt - wy0, 32'd3);
        check("n1_frdy_pulses", frdy_cnt - f0, 32'd1);
        check("n1_frdy_delay", frdy_cyc - last_hs_cyc, 32'd2);
        for (int i = 0; i < 4; i++) check("n1_mem_x", {16'd0, mem_x[i]}, 32'h10 + i);
        for (int i = 0; i < 3; i++) check("n1_mem_y", {16'd0, mem_y[i]}, 32'h14 + i);
        pulse_pf();
        check("n1_frames_done", {16'd0, frames_done}, 32'd1);

        // Arm held off by a non-scan system state.
        system_state = 16'd1;
        f0 = frdy_cnt;
        start_load(4, 3);
        for (int i = 0; i < 7; i++) send(16'h30 + i, i == 6, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("n2_ready_low", {31'd0, s_ready}, 32'd0);
        end
        check("n2_frdy_held", frdy_cnt - f0, 32'd0);
        system_state = 16'd3;
        wait_frdy(5);
        tick();
        check("n2_frdy_once", frdy_cnt - f0, 32'd1);
        pulse_pf();
        check("n2_frames_done", {16'd0, frames_done}, 32'd2);

        // Gapped stream keeps addresses contiguous.
        q_xa.delete(); q_ya.delete();
        start_load(2, 2);
        for (int i = 0; i < 4; i++) send(16'h50 + i, i == 3, 1);
        wait_frdy(5);
        check("n3_x_count", q_xa.size(), 32'd2);
        check("n3_y_count", q_ya.size(), 32'd2);
        if (q_xa.size() == 2 && q_ya.size() == 2) begin
            check("n3_x_addr0", q_xa[0], 32'd0);
            check("n3_x_addr1", q_xa[1], 32'd1);
            check("n3_y_addr0", q_ya[0], 32'd0);
            check("n3_y_addr1", q_ya[1], 32'd1);
        end
        pulse_pf();

        // s_last during X, then missing s_last at the end of Y.
        wx0 = wx_cnt; wy0 = wy_cnt; f0 = frdy_cnt;
        start_load(2, 2);
        send(16'h60, 0, 0);
        send(16'h61, 1, 0);
        tick();
        check("e1_load_err", {31'd0, load_err}, 32'd1);
        check("e1_x_writes", wx_cnt - wx0, 32'd1);
        check("e1_y_writes", wy_cnt - wy0, 32'd0);
        start_load(2, 2);
        check("e2_err_cleared", {31'd0, load_err}, 32'd0);
        for (int i = 0; i < 4; i++) send(16'h70 + i, 0, 0);
        repeat (3) tick();
        check("e2_load_err", {31'd0, load_err}, 32'd1);
        check("e2_no_frdy", frdy_cnt - f0, 32'd0);
        start_load(0, 3);
        check("e3_load_err", {31'd0, load_err}, 32'd1);
        repeat (2) tick();
        check("e3_ready_low", {31'd0, s_ready}, 32'd0);

        // Abort from RUN.
        start_load(2, 2);
        for (int i = 0; i < 4; i++) send(16'h80 + i, i == 3, 0);
        wait_frdy(5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("a1_busy", {31'd0, busy}, 32'd0);
        check("a1_frames", {16'd0, frames_done}, 32'd3);
        pulse_pf();
        tick();
        check("a1_pf_ignored", {16'd0, frames_done}, 32'd3);

        // Randomized traffic checked by the model every cycle.
        for (int c = 0; c < 4000; c++) begin
            system_state = ($urandom_range(0, 3) == 0) ? 16'd1 : 16'd3;
            xdata_points_number = ($urandom_range(0, 15) == 0) ? 16'd0 : 16'($urandom_range(1, 5));
            ydata_points_number = ($urandom_range(0, 15) == 0) ? 16'd0 : 16'($urandom_range(1, 5));
            load_start    = ($urandom_range(0, 7) == 0);
            abort         = ($urandom_range(0, 63) == 0);
            proc_finished = ($urandom_range(0, 3) == 0);
            s_valid       = ($urandom_range(0, 3) != 0);
            s_data        = 16'($urandom);
            s_last        = ((m_mode == MLoad) && (m_k == m_nx + m_ny - 1))
                            ^ ($urandom_range(0, 31) == 0);
            tick();
        end
        load_start = 0; abort = 0; proc_finished = 0; s_valid = 0; s_last = 0;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/scan_frame_loader.md
Name: scan_frame_loader

Overview:
- Write-side counterpart to the 3D scan signal generator.
- Accepts a host sample stream and fills the X and Y galvo waveform tables through their write ports.
- When the tables are complete, it issues the frame-ready handshake and holds until the generator reports that processing is finished.
- Sits between the host/command interface and the scan generator; a single instance serves one waveform table pair.

Parameters:
- ADDR_W, 16, width of table write addresses and point counters
- DATA_W, 16, width of waveform samples
- SCAN3D_STATE, 3, system_state code in which a frame may be armed

Ports:
- sys_clk  input  1  system clock
- sys_rst  input  1  asynchronous reset, active-high
- system_state  input  16  current system mode
- load_start  input  1  one-cycle pulse that starts a frame load
- abort  input  1  synchronous abort; returns the block to IDLE
- xdata_points_number  input  ADDR_W  X samples per frame
- ydata_points_number  input  ADDR_W  Y samples per frame
- s_valid  input  1  stream sample valid
- s_data  input  DATA_W  stream sample
- s_last  input  1  marks the final sample of the frame
- s_ready  output  1  stream ready
- wr_x_en  output  1  X table write strobe
- wr_x_addr  output  ADDR_W  X table write address
- wr_x_data  output  DATA_W  X table write data
- wr_y_en  output  1  Y table write strobe
- wr_y_addr  output  ADDR_W  Y table write address
- wr_y_data  output  DATA_W  Y table write data
- frame_rdy  output  1  one-cycle pulse: tables valid, start scan
- proc_finished  input  1  one-cycle pulse from the generator: scan complete
- busy  output  1  high in any state other than IDLE and ERR
- load_err  output  1  sticky error flag
- frames_done  output  16  count of completed frames, saturating

Behaviour:
- Reset (asynchronous, active-high). State goes to IDLE. All outputs are 0: s_ready, wr_*_en, wr_*_addr, wr_*_data, frame_rdy, busy, load_err, frames_done.
- States: IDLE, LOAD_X, LOAD_Y, ARM, RUN, ERR.
- IDLE: s_ready=0. On load_start, latch both point counts, clear load_err and the address counter.
  - If either latched count is 0, go to ERR.
  - Otherwise go to LOAD_X.
- LOAD_X: s_ready=1.
  - Each handshake (s_valid & s_ready) registers wr_x_en=1, wr_x_addr=counter and wr_x_data=s_data on the next cycle, then increments the counter.
  - The handshake with counter == nx-1 moves the state to LOAD_Y and resets the counter to 0.
  - s_last on any X handshake sends the state to ERR; that sample is not written.
- LOAD_Y: same mechanism on the wr_y_* port.
  - The handshake with counter == ny-1 and s_last=1 goes to ARM.
  - That handshake with s_last=0 goes to ERR; the sample is written.
  - s_last on an earlier Y handshake goes to ERR; that sample is not written.
- Write strobes are single-cycle registered pulses. Write latency is 1 cycle from handshake to strobe. Throughput is one sample per cycle; back-to-back handshakes produce consecutive addresses.
- ARM: s_ready=0. Wait until system_state == SCAN3D_STATE.
  - On the first cycle that condition holds, assert frame_rdy for exactly one cycle (registered) and go to RUN.
  - frame_rdy is never earlier than 2 cycles after the final handshake, so the final table write has already landed.
- RUN: wait for proc_finished. On the pulse, increment frames_done (saturating at 16'hFFFF) and go to IDLE.
- proc_finished is ignored in every state except RUN.
- load_start is ignored in every state except IDLE and ERR.
- ERR: load_err=1 and s_ready=0. Only load_start leaves ERR; it clears load_err and follows the IDLE start rules.
- abort is honoured in every state:
  - next state is IDLE;
  - s_ready, write strobes and frame_rdy are 0 from the next cycle on;
  - a write strobe already registered still completes;
  - load_err is cleared and frames_done is unchanged.
- abort and load_start in the same cycle: abort wins.
- abort and proc_finished in the same cycle while in RUN: frames_done still increments.
- Point counts are latched, so changing the count inputs during a load has no effect.
- busy = (state != IDLE) && (state != ERR).

Test Plan:
- nx=4, ny=3, 7 back-to-back samples 0x10..0x16 with s_last on the 7th. Expected:
  - X writes at addr 0..3 with data 0x10..0x13;
  - Y writes at addr 0..2 with data 0x14..0x16;
  - with system_state=3, frame_rdy pulses once, 2 cycles after the last handshake.
- Same load with system_state=1 held for 10 cycles, then 3. Expected: frame_rdy held off for those 10 cycles, then pulses 1 cycle; s_ready=0 throughout the wait.
- s_valid toggled every other cycle, nx=ny=2. Expected: addresses contiguous with no gaps or duplicates; 4 write strobes total.
- Protocol errors, nx=2, ny=2:
  - s_last on the 2nd sample gives load_err=1 and no wr_y_en;
  - omitted s_last on the 4th sample gives load_err=1 and no frame_rdy;
  - a following load_start clears load_err.
- nx=0 with load_start. Expected: ERR immediately, load_err=1, s_ready stays 0.
- RUN entered, then abort. Expected: IDLE next cycle, busy=0, frames_done unchanged; a later proc_finished is ignored. A full load followed by proc_finished increments frames_done 0 to 1.
